// File: rtl/mem_stage.sv
// Pipeline memory stage: issues load/store/push/pop to a handshaked data memory,
// owns the stack pointer, and passes non-memory results to MEM/WB in one cycle.
module mem_stage #(
  parameter logic [15:0] SP_INIT = 16'h07FF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ALU_result_mem,
  input  logic [15:0] Rs_data_mem,
  input  logic [15:0] Rd_data_mem,
  input  logic [2:0]  Rd_mem,
  input  logic        memRead_mem,
  input  logic        memWrite_mem,
  input  logic        regWrite_mem,
  input  logic        push_mem,
  input  logic        pop_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [15:0] dmem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic [15:0] sp,
  output logic        mem_fault
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_PUSH, OP_POP} op_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t     state, state_nxt;
  op_t        op_dec, op_q;
  logic       mem_op;
  logic       to_reached;
  logic [7:0] to_cnt;
  logic [2:0] rd_q;
  logic       regwrite_q;
  logic       stall_raw;

  assign mem_op     = push_mem | pop_mem | memRead_mem | memWrite_mem;
  assign to_reached = (to_cnt == TO_LIMIT);

  // Priority push > pop > load > store when several control bits are set.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    op_dec = OP_STORE;
    if (push_mem)         op_dec = OP_PUSH;
    else if (pop_mem)     op_dec = OP_POP;
    else if (memRead_mem) op_dec = OP_LOAD;
  end

  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    case (state)
      IDLE: begin
        stall_raw = mem_op;
        if (mem_op) state_nxt = BUSY;
      end
      BUSY: begin
        // Released on the completing or aborting cycle so EX/MEM advances on that edge.
        stall_raw = !dmem_ready && !to_reached;
        if (dmem_ready || to_reached) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall = rst_n & stall_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      sp          <= SP_INIT;
      mem_fault   <= 1'b0;
      to_cnt      <= '0;
      op_q        <= OP_LOAD;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
    end else begin
      mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            dmem_req    <= 1'b1;
            op_q        <= op_dec;
            rd_q        <= Rd_mem;
            regwrite_q  <= regWrite_mem;
            to_cnt      <= '0;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            case (op_dec)
              OP_LOAD: begin
                dmem_addr <= ALU_result_mem;
                dmem_we   <= 1'b0;
              end
              OP_STORE: begin
                dmem_addr  <= ALU_result_mem;
                dmem_wdata <= Rs_data_mem;
                dmem_we    <= 1'b1;
              end
              OP_PUSH: begin
                dmem_addr  <= sp;
                dmem_wdata <= Rd_data_mem;
                dmem_we    <= 1'b1;
              end
              default: begin
                dmem_addr <= sp + 16'd1;
                dmem_we   <= 1'b0;
              end
            endcase
          end else begin
            wb_valid    <= 1'b1;
            wb_regwrite <= regWrite_mem;
            wb_rd       <= Rd_mem;
            wb_data     <= ALU_result_mem;
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            if (op_q == OP_LOAD || op_q == OP_POP) begin
              wb_data     <= dmem_rdata;
              wb_regwrite <= regwrite_q;
            end else begin
              wb_regwrite <= 1'b0;
            end
            if (op_q == OP_PUSH) sp <= sp - 16'd1;
            if (op_q == OP_POP)  sp <= sp + 16'd1;
          end else if (to_reached) begin
            // Abort: the instruction retires without writeback and sp is untouched.
            dmem_req    <= 1'b0;
            mem_fault   <= 1'b1;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table with a writeback scoreboard,
// plus hand sequences for reset mid-request and ready asserted while idle.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu, rs, rdd, rdata;
  logic [2:0]  rd;
  logic        mrd, mwr, rw, push, pop, ready;

  logic        dmem_req, dmem_we, stall, wb_valid, wb_regwrite, mem_fault;
  logic [15:0] dmem_addr, dmem_wdata, wb_data, sp;
  logic [2:0]  wb_rd;
  logic        w_req, w_we, w_stall, w_wb_valid, w_wb_regwrite, w_fault;
  logic [15:0] w_addr, w_wdata, w_wb_data, w_sp;
  logic [2:0]  w_wb_rd;

  mem_stage #(.SP_INIT(16'h07FF), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ALU_result_mem(alu), .Rs_data_mem(rs), .Rd_data_mem(rdd),
    .Rd_mem(rd), .memRead_mem(mrd), .memWrite_mem(mwr), .regWrite_mem(rw), .push_mem(push),
    .pop_mem(pop), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(ready), .dmem_rdata(rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .sp(sp), .mem_fault(mem_fault));

  mem_stage #(.SP_INIT(16'h0000), .TIMEOUT(TO)) dut_w (
    .clk(clk), .rst_n(rst_n), .ALU_result_mem(alu), .Rs_data_mem(rs), .Rd_data_mem(rdd),
    .Rd_mem(rd), .memRead_mem(mrd), .memWrite_mem(mwr), .regWrite_mem(rw), .push_mem(push),
    .pop_mem(pop), .dmem_req(w_req), .dmem_we(w_we), .dmem_addr(w_addr),
    .dmem_wdata(w_wdata), .dmem_ready(ready), .dmem_rdata(rdata), .stall(w_stall),
    .wb_valid(w_wb_valid), .wb_regwrite(w_wb_regwrite), .wb_rd(w_wb_rd), .wb_data(w_wb_data),
    .sp(w_sp), .mem_fault(w_fault));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [2:0]  rd;
    logic [15:0] data;
    logic        chk;
  } exp_t;

  typedef struct {
    logic [4:0]  ctl;      // push, pop, memRead, memWrite, regWrite
    logic [15:0] alu, rs, rdd;
    logic [2:0]  rd;
    int          delay;    // BUSY cycle carrying ready; 0 = never
    logic [15:0] rdata;
    logic [15:0] e_addr;
    logic        e_we;
    logic [15:0] e_wdata;
    int          e_stalls;
    logic [15:0] e_sp;
    logic        e_rw;
    logic [15:0] e_data;
    logic        wrap;
    logic [15:0] w_addr, w_sp;
  } vec_t;

  exp_t sb[$];
  vec_t vt[11];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] ctl, input logic [15:0] a, input logic [15:0] s,
                              input logic [15:0] d, input logic [2:0] r, input int dly,
                              input logic [15:0] rdv, input logic [15:0] ea, input logic ewe,
                              input logic [15:0] ewd, input int est, input logic [15:0] esp,
                              input logic erw, input logic [15:0] edat, input logic wr,
                              input logic [15:0] wa, input logic [15:0] wsp);
    vec_t v;
    v.ctl = ctl; v.alu = a; v.rs = s; v.rdd = d; v.rd = r; v.delay = dly; v.rdata = rdv;
    v.e_addr = ea; v.e_we = ewe; v.e_wdata = ewd; v.e_stalls = est; v.e_sp = esp;
    v.e_rw = erw; v.e_data = edat; v.wrap = wr; v.w_addr = wa; v.w_sp = wsp;
    return v;
  endfunction

  task automatic drive_nop();
    {push, pop, mrd, mwr, rw} = 5'b0;
    alu = '0; rs = '0; rdd = '0; rd = '0;
  endtask

  // Writeback monitor: every wb_valid cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_on && wb_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wb_unexpected: got wb_valid=1 data=%h, expected no writeback", wb_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_regwrite", 32'(wb_regwrite), 32'(e.rw));
        if (e.chk) begin
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", 32'(wb_data), 32'(e.data));
        end
      end
    end
  end

  // Called #1 after a posedge with the DUT idle; returns #1 after a posedge.
  task automatic run_vec(input int idx, input vec_t v);
    logic is_mem, fault, exp_st;
    int   stalls, max_b;
    is_mem = |v.ctl[4:1];
    fault  = is_mem && (v.delay == 0);
    stalls = 0;
    {push, pop, mrd, mwr, rw} = v.ctl;
    alu = v.alu; rs = v.rs; rdd = v.rdd; rd = v.rd;
    if (!fault) sb.push_back('{rw: v.e_rw, rd: v.rd, data: v.e_data, chk: v.e_rw || !is_mem});
    @(negedge clk);
    stalls += int'(stall);
    if (!is_mem) begin
      check($sformatf("v%0d_idle_req", idx), 32'(dmem_req), 32'd0);
      check($sformatf("v%0d_stalls", idx), 32'(stalls), 32'(v.e_stalls));
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    max_b = fault ? TO + 1 : v.delay;
    for (int b = 1; b <= max_b; b++) begin
      if (v.delay == b) begin
        ready = 1'b1;
        rdata = v.rdata;
      end
      @(negedge clk);
      exp_st = fault ? (b <= TO) : (b != v.delay);
      stalls += int'(stall);
      check($sformatf("v%0d_b%0d_stall", idx, b), 32'(stall), 32'(exp_st));
      check($sformatf("v%0d_b%0d_req", idx, b), 32'(dmem_req), 32'd1);
      check($sformatf("v%0d_b%0d_addr", idx, b), 32'(dmem_addr), 32'(v.e_addr));
      check($sformatf("v%0d_b%0d_we", idx, b), 32'(dmem_we), 32'(v.e_we));
      if (v.e_we) check($sformatf("v%0d_b%0d_wdata", idx, b), 32'(dmem_wdata), 32'(v.e_wdata));
      check($sformatf("v%0d_b%0d_fault", idx, b), 32'(mem_fault), 32'd0);
      if (v.wrap && b == 1) check($sformatf("v%0d_wrap_addr", idx), 32'(w_addr), 32'(v.w_addr));
      @(posedge clk); #1;
      ready = 1'b0;
    end
    check($sformatf("v%0d_req_drop", idx), 32'(dmem_req), 32'd0);
    check($sformatf("v%0d_sp", idx), 32'(sp), 32'(v.e_sp));
    check($sformatf("v%0d_fault", idx), 32'(mem_fault), 32'(fault));
    check($sformatf("v%0d_stalls", idx), 32'(stalls), 32'(v.e_stalls));
    if (v.wrap) check($sformatf("v%0d_wrap_sp", idx), 32'(w_sp), 32'(v.w_sp));
    if (fault) begin
      check($sformatf("v%0d_abort_wb", idx), 32'(wb_valid), 32'd0);
      drive_nop();
      sb.push_back('{rw: 1'b0, rd: 3'd0, data: 16'h0000, chk: 1'b1});
      @(negedge clk);
      check($sformatf("v%0d_abort_stall", idx), 32'(stall), 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_fault_pulse", idx), 32'(mem_fault), 32'd0);
    end
  endtask

  initial begin
    //            ctl       alu       rs        rdd       rd  dly rdata     addr      we wdata     st sp        rw data      wr w_addr    w_sp
    vt[0]  = mk(5'b00001, 16'h1234, 16'h0000, 16'h0000, 5, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h07FF, 1, 16'h1234, 0, 16'h0000, 16'h0000);
    vt[1]  = mk(5'b00000, 16'h00FF, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h07FF, 0, 16'h00FF, 0, 16'h0000, 16'h0000);
    vt[2]  = mk(5'b00101, 16'h0040, 16'h0000, 16'h0000, 3, 3, 16'hBEEF, 16'h0040, 0, 16'h0000, 3, 16'h07FF, 1, 16'hBEEF, 0, 16'h0000, 16'h0000);
    vt[3]  = mk(5'b00011, 16'h0100, 16'h5A5A, 16'h0000, 1, 1, 16'h0000, 16'h0100, 1, 16'h5A5A, 1, 16'h07FF, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    vt[4]  = mk(5'b10000, 16'h0000, 16'h0000, 16'hAAAA, 0, 1, 16'h0000, 16'h07FF, 1, 16'hAAAA, 1, 16'h07FE, 0, 16'h0000, 1, 16'h0000, 16'hFFFF);
    vt[5]  = mk(5'b01001, 16'h0000, 16'h0000, 16'h0000, 2, 1, 16'hAAAA, 16'h07FF, 0, 16'h0000, 1, 16'h07FF, 1, 16'hAAAA, 1, 16'h0000, 16'h0000);
    vt[6]  = mk(5'b10101, 16'h0300, 16'h0000, 16'h1111, 6, 2, 16'h0000, 16'h07FF, 1, 16'h1111, 2, 16'h07FE, 0, 16'h0000, 1, 16'h0000, 16'hFFFF);
    vt[7]  = mk(5'b01011, 16'h0500, 16'h2222, 16'h0000, 4, 1, 16'h1111, 16'h07FF, 0, 16'h0000, 1, 16'h07FF, 1, 16'h1111, 1, 16'h0000, 16'h0000);
    vt[8]  = mk(5'b00010, 16'h0200, 16'h7777, 16'h0000, 0, 0, 16'h0000, 16'h0200, 1, 16'h7777, 5, 16'h07FF, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    vt[9]  = mk(5'b00001, 16'h4321, 16'h0000, 16'h0000, 7, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h07FF, 1, 16'h4321, 0, 16'h0000, 16'h0000);
    vt[10] = mk(5'b00101, 16'h0010, 16'h0000, 16'h0000, 1, 1, 16'h0001, 16'h0010, 0, 16'h0000, 1, 16'h07FF, 1, 16'h0001, 0, 16'h0000, 16'h0000);

    rst_n = 1'b0;
    ready = 1'b0;
    rdata = '0;
    drive_nop();
    #12;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sp", 32'(sp), 32'h07FF);
    check("rst_wrap_sp", 32'(w_sp), 32'h0000);
    check("rst_wb", 32'({wb_valid, wb_regwrite, wb_rd, wb_data}), 32'd0);

    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_on = 1'b1;
    for (int i = 0; i < 11; i++) run_vec(i, vt[i]);

    // Reset arriving in the middle of a pending load.
    mrd = 1'b1; rw = 1'b1; alu = 16'h0080; rd = 3'd3;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("midbusy_req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midbusy_rst_req", 32'(dmem_req), 32'd0);
    check("midbusy_rst_stall", 32'(stall), 32'd0);
    check("midbusy_rst_sp", 32'(sp), 32'h07FF);
    check("midbusy_rst_wb", 32'({wb_valid, wb_regwrite, wb_rd, wb_data}), 32'd0);
    check("midbusy_rst_fault", 32'(mem_fault), 32'd0);
    drive_nop();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Ready while idle must not start or complete anything.
    ready = 1'b1;
    run_vec(11, vt[1]);
    ready = 1'b0;
    run_vec(12, vt[0]);
    drive_nop();
    @(negedge clk); #1;
    mon_on = 1'b0;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
